// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding and a small vote helper.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX front end: 2-flop synchroniser, per-bit oversample counter and 3-sample majority vote.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic rx_clk_en,
  input  logic rx,
  input  logic cnt_clr,
  output logic rxs,
  output logic bit_strobe,
  output logic bit_value,
  output logic bit_end
);

  localparam int unsigned M    = OVERSAMPLE / 2;
  localparam int unsigned CntW = $clog2(OVERSAMPLE);

  localparam logic [CntW-1:0] SFirst = CntW'(M - 1);
  localparam logic [CntW-1:0] SMid   = CntW'(M);
  localparam logic [CntW-1:0] SLast  = CntW'(M + 1);
  localparam logic [CntW-1:0] SEnd   = CntW'(OVERSAMPLE - 1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            samp0_q, samp0_d;
  logic            samp1_q, samp1_d;

  assign rxs = sync_q[1];

  always_comb begin
    cnt_d   = cnt_q;
    samp0_d = samp0_q;
    samp1_d = samp1_q;
    if (rx_clk_en) begin
      if (cnt_clr || cnt_q == SEnd) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
      if (cnt_q == SFirst) samp0_d = rxs;
      if (cnt_q == SMid)   samp1_d = rxs;
    end
  end

  // The third sample is the live rxs at s = M+1, so the vote is ready that same tick.
  assign bit_strobe = rx_clk_en && (cnt_q == SLast);
  assign bit_end    = rx_clk_en && (cnt_q == SEnd);
  assign bit_value  = majority3(samp0_q, samp1_q, rxs);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      samp0_q <= 1'b1;
      samp1_q <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], rx};
      cnt_q   <= cnt_d;
      samp0_q <= samp0_d;
      samp1_q <= samp1_d;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with parity/framing/overrun reporting and a
// valid/ready output holding register.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 rx_clk_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  input  logic                 overrun_clr,
  output logic                 busy
);

  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BITS - 1);
  localparam logic LastStop = (STOP_BITS == 2);

  rx_state_e state_q, state_d;

  logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 fe_pend_q, fe_pend_d;
  logic                 pe_pend_q, pe_pend_d;
  logic                 armed_q, armed_d;

  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;

  logic rxs, bit_strobe, bit_value, bit_end, cnt_clr;
  logic commit, commit_fe, accept;

  uart_rx_sampler #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_sampler (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .rx_clk_en  (rx_clk_en),
    .rx         (rx),
    .cnt_clr    (cnt_clr),
    .rxs        (rxs),
    .bit_strobe (bit_strobe),
    .bit_value  (bit_value),
    .bit_end    (bit_end)
  );

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    fe_pend_d  = fe_pend_q;
    pe_pend_d  = pe_pend_q;
    armed_d    = armed_q;
    commit     = 1'b0;
    commit_fe  = 1'b0;
    cnt_clr    = 1'b0;
    if (rx_clk_en) begin
      unique case (state_q)
        StIdle: begin
          cnt_clr = 1'b1;
          if (rxs) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            // This tick counts as s = 0 of the start bit.
            state_d    = StStart;
            cnt_clr    = 1'b0;
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
            fe_pend_d  = 1'b0;
            pe_pend_d  = 1'b0;
          end
        end
        StStart: begin
          if (bit_strobe && bit_value) begin
            state_d = StIdle;
            cnt_clr = 1'b1;
          end else if (bit_end) begin
            state_d = StData;
          end
        end
        StData: begin
          if (bit_strobe) shift_d = {bit_value, shift_q[DATA_BITS-1:1]};
          if (bit_end) begin
            if (bit_idx_q == LastIdx) begin
              state_d = (PARITY != PARITY_NONE) ? StParity : StStop;
            end else begin
              bit_idx_d = bit_idx_q + IdxW'(1);
            end
          end
        end
        StParity: begin
          if (bit_strobe) begin
            pe_pend_d = (PARITY == PARITY_ODD) ? ~(^shift_q ^ bit_value)
                                               : (^shift_q ^ bit_value);
          end
          if (bit_end) state_d = StStop;
        end
        StStop: begin
          if (bit_strobe) begin
            if (!bit_value) fe_pend_d = 1'b1;
            if (stop_idx_q == LastStop) begin
              // Commit mid-bit and drop to idle early to leave half a bit of resync margin.
              commit    = 1'b1;
              commit_fe = fe_pend_q | ~bit_value;
              state_d   = StIdle;
              cnt_clr   = 1'b1;
              if (commit_fe) armed_d = 1'b0;
            end
          end else if (bit_end) begin
            stop_idx_d = 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  assign accept = rx_valid_q && rx_ready;

  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = overrun_q;
    if (overrun_clr) overrun_d = 1'b0;
    if (commit) begin
      if (!rx_valid_q || accept) begin
        rx_data_d    = shift_q;
        rx_valid_d   = 1'b1;
        frame_err_d  = commit_fe;
        parity_err_d = pe_pend_q;
      end else begin
        // A new overrun outranks a simultaneous clear.
        overrun_d = 1'b1;
      end
    end else if (accept) begin
      rx_valid_d   = 1'b0;
      frame_err_d  = 1'b0;
      parity_err_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= StIdle;
      bit_idx_q    <= '0;
      stop_idx_q   <= 1'b0;
      shift_q      <= '0;
      fe_pend_q    <= 1'b0;
      pe_pend_q    <= 1'b0;
      armed_q      <= 1'b1;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      stop_idx_q   <= stop_idx_d;
      shift_q      <= shift_d;
      fe_pend_q    <= fe_pend_d;
      pe_pend_q    <= pe_pend_d;
      armed_q      <= armed_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1, 8E1 and 7O2 instances share one serial line.
module tb_uart_rx_param;

  localparam int unsigned Os = 16;
  localparam int BitClks = 2 * Os;  // one tick every other sys_clk

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  logic rx_clk_en = 1'b0;
  logic rx = 1'b1;
  logic rx_ready = 1'b1;
  logic overrun_clr = 1'b0;

  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic v0, v1, v2, fe0, fe1, fe2, pe0, pe1, pe2, ov0, ov1, ov2, b0, b1, b2;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) rx_clk_en <= ~rx_clk_en;

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(Os), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_clk_en(rx_clk_en), .rx(rx),
    .rx_data(d0), .rx_valid(v0), .rx_ready(rx_ready), .frame_err(fe0),
    .parity_err(pe0), .overrun(ov0), .overrun_clr(overrun_clr), .busy(b0)
  );
  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(Os), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_clk_en(rx_clk_en), .rx(rx),
    .rx_data(d1), .rx_valid(v1), .rx_ready(rx_ready), .frame_err(fe1),
    .parity_err(pe1), .overrun(ov1), .overrun_clr(overrun_clr), .busy(b1)
  );
  uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(Os), .PARITY(1), .STOP_BITS(2)) u_7o2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_clk_en(rx_clk_en), .rx(rx),
    .rx_data(d2), .rx_valid(v2), .rx_ready(rx_ready), .frame_err(fe2),
    .parity_err(pe2), .overrun(ov2), .overrun_clr(overrun_clr), .busy(b2)
  );

  logic       vld [3];
  logic [8:0] dat [3];
  logic       fer [3];
  logic       per [3];
  logic       bsy [3];

  always_comb begin
    vld[0] = v0;  vld[1] = v1;  vld[2] = v2;
    dat[0] = 9'(d0); dat[1] = 9'(d1); dat[2] = 9'(d2);
    fer[0] = fe0; fer[1] = fe1; fer[2] = fe2;
    per[0] = pe0; per[1] = pe1; per[2] = pe2;
    bsy[0] = b0;  bsy[1] = b1;  bsy[2] = b2;
  end

  // Capture each rising edge of rx_valid per instance.
  int         vcnt  [3] = '{0, 0, 0};
  logic       vprev [3] = '{1'b0, 1'b0, 1'b0};
  logic [8:0] cap_data [3];
  logic       cap_fe [3];
  logic       cap_pe [3];

  always @(negedge sys_clk) begin
    for (int k = 0; k < 3; k++) begin
      vprev[k] <= vld[k];
      if (vld[k] && !vprev[k]) begin
        vcnt[k]     <= vcnt[k] + 1;
        cap_data[k] <= dat[k];
        cap_fe[k]   <= fer[k];
        cap_pe[k]   <= per[k];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rx = 1'b1;
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BitClks) @(negedge sys_clk);
  endtask

  // Bit b starts at a negedge just before a tick, so s = 8 of any bit samples rx as driven
  // from bit-relative negedge 16 and the last stop bit commits at bit-relative posedge 20.
  task automatic send_frame(input logic [15:0] bits, input int n, input int spike_bit,
                            input logic ready_pulse);
    while (rx_clk_en !== 1'b1) @(negedge sys_clk);
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < BitClks; c++) begin
        rx = bits[b] ^ ((b == spike_bit) && (c == 16));
        if (ready_pulse && b == n - 1) rx_ready = (c == 20);
        @(negedge sys_clk);
      end
    end
  endtask

  typedef struct {
    int         dut;
    logic [8:0] data;
    int         ndata;
    logic       has_par;
    logic       par_bit;
    logic [1:0] stops;
    int         nstop;
    logic [8:0] exp_data;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  task automatic build(input vec_t v, output logic [15:0] bits, output int n);
    bits = '1;
    bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < v.ndata; i++) begin
      bits[n] = v.data[i];
      n++;
    end
    if (v.has_par) begin
      bits[n] = v.par_bit;
      n++;
    end
    for (int i = 0; i < v.nstop; i++) begin
      bits[n] = v.stops[i];
      n++;
    end
  endtask

  vec_t        vecs [11];
  logic [15:0] fbits;
  int          fn;
  int          base;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0, 9'h0A5, 8, 1'b0, 1'b0, 2'b11, 1, 9'h0A5, 1'b0, 1'b0};
    vecs[1]  = '{0, 9'h000, 8, 1'b0, 1'b0, 2'b11, 1, 9'h000, 1'b0, 1'b0};
    vecs[2]  = '{0, 9'h0FF, 8, 1'b0, 1'b0, 2'b11, 1, 9'h0FF, 1'b0, 1'b0};
    vecs[3]  = '{0, 9'h03C, 8, 1'b0, 1'b0, 2'b10, 1, 9'h03C, 1'b1, 1'b0};
    vecs[4]  = '{1, 9'h03C, 8, 1'b1, 1'b1, 2'b11, 1, 9'h03C, 1'b0, 1'b1};
    vecs[5]  = '{1, 9'h03C, 8, 1'b1, 1'b0, 2'b11, 1, 9'h03C, 1'b0, 1'b0};
    vecs[6]  = '{1, 9'h001, 8, 1'b1, 1'b1, 2'b11, 1, 9'h001, 1'b0, 1'b0};
    vecs[7]  = '{1, 9'h080, 8, 1'b1, 1'b0, 2'b11, 1, 9'h080, 1'b0, 1'b1};
    vecs[8]  = '{2, 9'h05A, 7, 1'b1, 1'b1, 2'b11, 2, 9'h05A, 1'b0, 1'b0};
    vecs[9]  = '{2, 9'h05A, 7, 1'b1, 1'b0, 2'b11, 2, 9'h05A, 1'b0, 1'b1};
    vecs[10] = '{2, 9'h023, 7, 1'b1, 1'b0, 2'b01, 2, 9'h023, 1'b1, 1'b0};

    @(negedge sys_clk);
    do_reset();
    check("rst_valid_8n1", 32'(v0), 32'd0);
    check("rst_data_8n1", 32'(d0), 32'd0);
    check("rst_err_8n1", 32'({fe0, pe0}), 32'd0);
    check("rst_overrun_8n1", 32'(ov0), 32'd0);
    check("rst_busy_all", 32'({b0, b1, b2}), 32'd0);
    check("rst_valid_7o2", 32'(v2), 32'd0);
    idle_bits(1);

    // Table-driven frames.
    for (int i = 0; i < 11; i++) begin
      if (i == 0 || vecs[i].dut != vecs[i-1].dut) do_reset();
      build(vecs[i], fbits, fn);
      base = vcnt[vecs[i].dut];
      send_frame(fbits, fn, -1, 1'b0);
      idle_bits(3);
      check($sformatf("vec%0d_count", i), 32'(vcnt[vecs[i].dut] - base), 32'd1);
      check($sformatf("vec%0d_data", i), 32'(cap_data[vecs[i].dut]), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_fe", i), 32'(cap_fe[vecs[i].dut]), 32'(vecs[i].exp_fe));
      check($sformatf("vec%0d_pe", i), 32'(cap_pe[vecs[i].dut]), 32'(vecs[i].exp_pe));
      check($sformatf("vec%0d_busy", i), 32'(bsy[vecs[i].dut]), 32'd0);
    end

    // False start: 4-tick low glitch, rejected at s = M+1 (bit-relative posedge 20).
    do_reset();
    base = vcnt[0];
    while (rx_clk_en !== 1'b1) @(negedge sys_clk);
    rx = 1'b0;
    repeat (8) @(negedge sys_clk);
    rx = 1'b1;
    check("glitch_busy_early", 32'(b0), 32'd1);
    repeat (12) @(negedge sys_clk);
    check("glitch_busy_before_vote", 32'(b0), 32'd1);
    @(negedge sys_clk);
    check("glitch_busy_after_vote", 32'(b0), 32'd0);
    idle_bits(12);
    check("glitch_no_word", 32'(vcnt[0] - base), 32'd0);

    // Single-sample spike at s = M inside data bit 2 of 0x55.
    base = vcnt[0];
    send_frame(16'hFEAA, 10, 3, 1'b0);
    idle_bits(3);
    check("spike_count", 32'(vcnt[0] - base), 32'd1);
    check("spike_data", 32'(cap_data[0]), 32'h55);
    check("spike_fe", 32'(cap_fe[0]), 32'd0);

    // Break: low stop bit then line held low for 3 more frame times.
    base = vcnt[0];
    send_frame(16'h0000, 10, -1, 1'b0);
    rx = 1'b0;
    repeat (30 * BitClks) @(negedge sys_clk);
    idle_bits(3);
    check("break_count", 32'(vcnt[0] - base), 32'd1);
    check("break_data", 32'(cap_data[0]), 32'h00);
    check("break_fe", 32'(cap_fe[0]), 32'd1);
    base = vcnt[0];
    send_frame({6'h3F, 1'b1, 8'h12, 1'b0}, 10, -1, 1'b0);
    idle_bits(3);
    check("after_break_count", 32'(vcnt[0] - base), 32'd1);
    check("after_break_data", 32'(cap_data[0]), 32'h12);
    check("after_break_fe", 32'(cap_fe[0]), 32'd0);

    // Overrun with consumer stalled, then accept-and-load in the commit cycle.
    rx_ready = 1'b0;
    send_frame({6'h3F, 1'b1, 8'h11, 1'b0}, 10, -1, 1'b0);
    idle_bits(2);
    check("ovr_first_valid", 32'(v0), 32'd1);
    check("ovr_first_data", 32'(d0), 32'h11);
    check("ovr_first_flag", 32'(ov0), 32'd0);
    send_frame({6'h3F, 1'b1, 8'h22, 1'b0}, 10, -1, 1'b0);
    idle_bits(2);
    check("ovr_flag", 32'(ov0), 32'd1);
    check("ovr_kept_data", 32'(d0), 32'h11);
    check("ovr_kept_valid", 32'(v0), 32'd1);
    overrun_clr = 1'b1;
    @(negedge sys_clk);
    overrun_clr = 1'b0;
    check("ovr_cleared", 32'(ov0), 32'd0);
    send_frame({6'h3F, 1'b1, 8'h33, 1'b0}, 10, -1, 1'b1);
    idle_bits(1);
    check("swap_valid", 32'(v0), 32'd1);
    check("swap_data", 32'(d0), 32'h33);
    check("swap_no_overrun", 32'(ov0), 32'd0);
    rx_ready = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("swap_drained", 32'(v0), 32'd0);

    // 7O2: reset in the middle of DATA aborts the frame.
    do_reset();
    base = vcnt[2];
    send_frame(16'b0000_0000_0000_0100, 4, -1, 1'b0);
    check("abort_busy_before", 32'(b2), 32'd1);
    do_reset();
    check("abort_busy_after", 32'(b2), 32'd0);
    idle_bits(14);
    check("abort_no_word", 32'(vcnt[2] - base), 32'd0);
    check("abort_valid_low", 32'(v2), 32'd0);
    base = vcnt[2];
    send_frame({4'hF, 2'b11, 1'b1, 7'h5A, 1'b0}, 11, -1, 1'b0);
    idle_bits(2);
    check("post_abort_count", 32'(vcnt[2] - base), 32'd1);
    check("post_abort_data", 32'(cap_data[2]), 32'h5A);
    check("post_abort_err", 32'({cap_fe[2], cap_pe[2]}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
